// File: rtl/apb_master_if.sv
// APB bus bundle between the command-driven master and a responder.
interface apb_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [3:0]        pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, SETUP/ACCESS on the bus,
// one-cycle response pulse out, with an ACCESS wait-state timeout.
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    apb_master_if.master      apb
);
    localparam int CW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   wcnt;
    logic            done;
    logic            tmo;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == RESP);
    assign apb.psel    = (state == SETUP) || (state == ACCESS);
    assign apb.penable = (state == ACCESS);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    // Completion takes priority over the timeout in the same cycle.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE:   if (cmd_valid) state_n = SETUP;
            SETUP:  state_n = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (wcnt == CW'(TMO_CYC - 1)) begin
                    tmo     = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            apb.pwrite <= 1'b0;
            apb.paddr  <= '0;
            apb.pwdata <= '0;
            apb.pstrb  <= 4'b0000;
            wcnt       <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                apb.pwrite <= cmd_write;
                apb.paddr  <= cmd_addr;
                apb.pwdata <= cmd_write ? cmd_wdata : '0;
                apb.pstrb  <= cmd_write ? cmd_strb : 4'b0000;
                wcnt       <= '0;
            end
            if (state == ACCESS && !apb.pready) begin
                wcnt <= wcnt + 1'b1;
            end
            if (done) begin
                rsp_rdata <= apb.pwrite ? '0 : apb.prdata;
                rsp_err   <= 1'b0;
            end else if (tmo) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, APB address width; DATA_W, default 16, APB data width; TMO_CYC, default 255, maximum ACCESS cycles before abort.
REQ-002 sys_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 sys_rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  ADDR_W  target address.
REQ-008 cmd_wdata  input  DATA_W  write data.
REQ-009 cmd_strb  input  4  write byte strobes.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 paddr  output  ADDR_W; pwdata  output  DATA_W; pstrb  output  4  APB address, data and strobes.
REQ-016 prdata  input  DATA_W; pready  input  1  APB responder return.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-018 cmd_ready SHALL equal (state == IDLE), combinationally; no other state accepts commands.
REQ-019 On cmd_valid && cmd_ready, the block SHALL latch cmd_write, cmd_addr, cmd_wdata and cmd_strb and go IDLE -> SETUP.
REQ-020 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then go to ACCESS.
REQ-021 ACCESS SHALL hold psel=1 and penable=1; paddr, pwrite, pwdata and pstrb SHALL stay constant from SETUP through the end of ACCESS.
REQ-022 pstrb SHALL be 4'b0000 for reads; pwdata SHALL be the latched data for writes and 0 for reads.
REQ-023 In ACCESS, a wait counter SHALL count cycles with pready=0 and reset to 0 on entry to SETUP.
REQ-024 In ACCESS with pready=1, the block SHALL capture prdata into rsp_rdata for a read (0 for a write), clear rsp_err, and go to RESP.
REQ-025 If the counter reaches TMO_CYC with pready still 0, the block SHALL abort: rsp_err=1, rsp_rdata=0, go to RESP; if pready=1 in that same cycle, completion wins with rsp_err=0.
REQ-026 RESP SHALL last one cycle with rsp_valid=1 and psel=penable=0, then go to IDLE; no backpressure applies.
REQ-027 Zero-wait latency SHALL be 3 cycles from the accepting edge to the rsp_valid cycle; each wait state adds one cycle.
REQ-028 In IDLE, psel=penable=0; paddr, pwrite, pwdata and pstrb SHALL hold their last values.
REQ-029 rsp_rdata and rsp_err SHALL hold until the next response overwrites them.
REQ-030 pready and prdata SHALL be ignored outside ACCESS.
REQ-031 Back-to-back commands SHALL be accepted in the IDLE cycle after RESP, giving at most one command per 4 cycles.

Reset
REQ-032 Asserting sys_rst SHALL immediately set state=IDLE and clear psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, the counter and busy.
REQ-033 Reset during SETUP or ACCESS SHALL drop psel/penable asynchronously, discard the command and produce no response.
REQ-034 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-035 Write 0x004 / data 0xA5C3 / strb 0xF, pready tied 1 -> SETUP then ACCESS with pwrite=1, paddr=0x004; rsp_valid 3 cycles after accept; rsp_err=0; rsp_rdata=0.
REQ-036 Read 0x008, pready low for 2 ACCESS cycles, prdata=0x1234 -> pstrb=0; penable high 3 cycles; rsp_rdata=0x1234 at cycle 5.
REQ-037 TMO_CYC=4, read with pready stuck 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0; cmd_ready=1 the next cycle.
REQ-038 cmd_valid held high for 3 commands -> cmd_ready pulses once per 4 cycles; no APB overlap; 3 responses returned in order.
REQ-039 sys_rst asserted mid-ACCESS -> psel=penable=0 with no clock edge; no rsp_valid; first command after release completes normally.
REQ-040 pready=1 exactly on the TMO_CYC-th cycle -> normal completion, rsp_err=0.
